// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// the counter-width helper.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1; called as clog2(N+1) so the step
    // counter can reach N.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/divider_if.sv
// Operand/result handshake between a controller (master) and the divider
// (slave): start pulse in, one-cycle done strobe out.
interface divider_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         ready;
    logic         done;
    logic [N-1:0] quot;
    logic [N-1:0] rem;
    logic         dz;

    modport master (
        output start, a, b,
        input  ready, done, quot, rem, dz
    );

    modport slave (
        input  start, a, b,
        output ready, done, quot, rem, dz
    );
endinterface

// File: rtl/divider_subtractor.sv
// Combinational W-bit ripple-borrow subtractor (x - y), the subtract-side
// mirror of the datapath adder; borrow=1 means x < y.
module subtractor #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic [W-1:0] diff,
    output logic         borrow
);
    logic bw;

    always_comb begin
        bw   = 1'b0;
        diff = '0;
        for (int i = 0; i < W; i++) begin
            diff[i] = x[i] ^ y[i] ^ bw;
            bw      = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & bw);
        end
        borrow = bw;
    end
endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional DIVIDER_DZ_CHECK_EN: short-circuits b=0 straight to DONE with dz=1.
module divider
    import div_pkg::*;
#(
    parameter int N = 8
) (
    input  logic       clk,
    input  logic       clr,
    divider_if.slave   bus
);
    localparam int CW = clog2(N + 1);

    state_t         state_reg, state_next;
    logic [CW-1:0]  count_reg, count_next;
    logic [N-1:0]   r_reg, r_next;
    logic [N-1:0]   q_reg, q_next;
    logic [N:0]     d_reg, d_next;
    logic           ready_reg, ready_next;
    logic           done_reg, done_next;
    logic           dz_reg, dz_next;
    logic [N-1:0]   quot_reg, quot_next;
    logic [N-1:0]   rem_reg, rem_next;

    logic [N:0]     t;
    logic [N:0]     diff;
    logic           borrow;
    logic           dz_hit;

    assign t = {r_reg, q_reg[N-1]};

    subtractor #(.W(N + 1)) u_sub (
        .x      (t),
        .y      (d_reg),
        .diff   (diff),
        .borrow (borrow)
    );

`ifdef DIVIDER_DZ_CHECK_EN
    assign dz_hit = (bus.b == '0);
`else
    assign dz_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        r_next     = r_reg;
        q_next     = q_reg;
        d_next     = d_reg;
        dz_next    = dz_reg;
        quot_next  = quot_reg;
        rem_next   = rem_reg;

        case (state_reg)
            IDLE, DONE: begin
                // DONE also accepts so a held start sustains one divide per N+2 cycles
                if (bus.start) begin
                    d_next     = {1'b0, bus.b};
                    q_next     = bus.a;
                    r_next     = '0;
                    count_next = '0;
                    if (dz_hit) begin
                        state_next = DONE;
                        quot_next  = '1;
                        rem_next   = bus.a;
                        dz_next    = 1'b1;
                    end else begin
                        state_next = CALC;
                    end
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (count_reg == CW'(N)) begin
                    state_next = DONE;
                    quot_next  = q_reg;
                    rem_next   = r_reg;
                    dz_next    = 1'b0;
                end else begin
                    // Restoring step: both T and T-D fit in N bits whenever chosen
                    r_next     = borrow ? t[N-1:0] : diff[N-1:0];
                    q_next     = {q_reg[N-2:0], ~borrow};
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == IDLE);
        done_next  = (state_next == DONE);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_reg <= IDLE;
            count_reg <= '0;
            r_reg     <= '0;
            q_reg     <= '0;
            d_reg     <= '0;
            ready_reg <= 1'b1;
            done_reg  <= 1'b0;
            dz_reg    <= 1'b0;
            quot_reg  <= '0;
            rem_reg   <= '0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            r_reg     <= r_next;
            q_reg     <= q_next;
            d_reg     <= d_next;
            ready_reg <= ready_next;
            done_reg  <= done_next;
            dz_reg    <= dz_next;
            quot_reg  <= quot_next;
            rem_reg   <= rem_next;
        end
    end

    assign bus.ready = ready_reg;
    assign bus.done  = done_reg;
    assign bus.dz    = dz_reg;
    assign bus.quot  = quot_reg;
    assign bus.rem   = rem_reg;
endmodule
